wallace_mult_pipe: RTL and testbench



---
 rtl/wallace_pkg.sv | 31 +++
 rtl/wallace_csa_row.sv | 18 +
 rtl/wallace_mult_pipe.sv | 146 ++++++++++++++
 tb/tb_wallace_mult_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wallace_pkg.sv
// wallace_pkg: shared limits, pipeline depth and CSA tree sizing helpers for wallace_mult_pipe
package wallace_pkg;

    localparam int WIDTH_MIN  = 4;
    localparam int WIDTH_MAX  = 32;
    localparam int TAG_W_MIN  = 1;
    localparam int TAG_W_MAX  = 16;
    localparam int PIPE_DEPTH = 3;

    // rows left after lvl levels of 3:2 compression, starting from n rows
    function automatic int csa_rows(input int n, input int lvl);
        int r;
        r = n;
        for (int i = 0; i < lvl; i++) r = 2 * (r / 3) + r % 3;
        return r;
    endfunction

    // levels of 3:2 compression needed to bring n rows down to two
    function automatic int csa_levels(input int n);
        int r;
        int l;
        r = n;
        l = 0;
        while (r > 2) begin
            r = 2 * (r / 3) + r % 3;
            l++;
        end
        return l;
    endfunction

endpackage

// File: rtl/wallace_csa_row.sv
// wallace_csa_row: one row of 3:2 compressors; columns with a zero input collapse to half adders
module wallace_csa_row
    import wallace_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    assign sum   = a ^ b ^ c;
    // carry is pre-shifted into its weight; the carry out of the top column is dropped (mod 2^W)
    assign carry = {(a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]), 1'b0};

endmodule

// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe: 3-stage valid/ready Wallace-tree multiplier with sideband tag.
// Define WALLACE_SIGNED_EN to compile in per-transaction two's-complement mode (Baugh-Wooley);
// without it in_signed is ignored and every product is unsigned.
module wallace_mult_pipe
    import wallace_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int P = 2 * WIDTH;
`ifdef WALLACE_SIGNED_EN
    localparam int NPP = WIDTH + 1;
`else
    localparam int NPP = WIDTH;
`endif
    localparam int LV = csa_levels(NPP);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || TAG_W < TAG_W_MIN || TAG_W > TAG_W_MAX) begin : g_bad_cfg
        $error("wallace_mult_pipe: WIDTH or TAG_W out of range");
    end

    logic [PIPE_DEPTH-1:0] vld;
    logic                  en1, en2, en3;
    logic [WIDTH-1:0]      a1, b1;
    logic [TAG_W-1:0]      tag1, tag2;
    logic [P-1:0]          sum2, car2;
    logic [P-1:0]          tree [0:LV][0:NPP-1];

    // a stage loads when the stage after it is empty or draining this cycle
    assign en3       = !vld[2] || out_ready;
    assign en2       = !vld[1] || en3;
    assign en1       = !vld[0] || en2;
    assign in_ready  = en1;
    assign out_valid = vld[2];

`ifdef WALLACE_SIGNED_EN
    logic s1;

    // S1 mode bit travels with its operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s1 <= 1'b0;
        else if (en1 && in_valid) s1 <= in_signed;
    end

    // Baugh-Wooley: invert the sign-row/sign-column cross terms, add 2^W and 2^(2W-1)
    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
        localparam logic [WIDTH-1:0] INV = (i == WIDTH - 1) ? {1'b0, {(WIDTH-1){1'b1}}}
                                                            : {1'b1, {(WIDTH-1){1'b0}}};
        assign tree[0][i] = {{WIDTH{1'b0}}, (a1 & {WIDTH{b1[i]}}) ^ (INV & {WIDTH{s1}})} << i;
    end
    assign tree[0][WIDTH] = ({{(P-1){1'b0}}, s1} << WIDTH) | ({{(P-1){1'b0}}, s1} << (P - 1));
`else
    logic unused_signed;
    assign unused_signed = in_signed;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
        assign tree[0][i] = {{WIDTH{1'b0}}, a1 & {WIDTH{b1[i]}}} << i;
    end
`endif

    // each level compresses groups of three rows into two and passes the leftovers through
    for (genvar l = 0; l < LV; l++) begin : g_lvl
        localparam int N  = csa_rows(NPP, l);
        localparam int NN = csa_rows(NPP, l + 1);
        localparam int G  = N / 3;
        for (genvar g = 0; g < G; g++) begin : g_csa
            wallace_csa_row #(.W(P)) u_row (
                .a    (tree[l][3*g]),
                .b    (tree[l][3*g+1]),
                .c    (tree[l][3*g+2]),
                .sum  (tree[l+1][2*g]),
                .carry(tree[l+1][2*g+1])
            );
        end
        for (genvar r = 3 * G; r < N; r++) begin : g_pass
            assign tree[l+1][2*G+r-3*G] = tree[l][r];
        end
        for (genvar z = NN; z < NPP; z++) begin : g_zero
            assign tree[l+1][z] = '0;
        end
    end

    // S1: capture operands and tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld[0] <= 1'b0;
            a1     <= '0;
            b1     <= '0;
            tag1   <= '0;
        end else if (en1) begin
            vld[0] <= in_valid;
            if (in_valid) begin
                a1   <= in_a;
                b1   <= in_b;
                tag1 <= in_tag;
            end
        end
    end

    // S2: register the redundant sum/carry pair left by the CSA tree
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld[1] <= 1'b0;
            sum2   <= '0;
            car2   <= '0;
            tag2   <= '0;
        end else if (en2) begin
            vld[1] <= vld[0];
            if (vld[0]) begin
                sum2 <= tree[LV][0];
                car2 <= tree[LV][1];
                tag2 <= tag1;
            end
        end
    end

    // S3: final carry-propagate add; held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld[2]      <= 1'b0;
            out_product <= '0;
            out_tag     <= '0;
        end else if (en3) begin
            vld[2] <= vld[1];
            if (vld[1]) begin
                out_product <= sum2 + car2;
                out_tag     <= tag2;
            end
        end
    end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// tb_wallace_mult_pipe: directed checks on an 8-bit instance plus random sweeps at 4, 8 and 16 bits
module tb_wallace_mult_pipe;

`ifdef WALLACE_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic clk;
    logic drst_n, rrst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    logic        in_valid, in_ready, in_signed, out_valid, out_ready;
    logic [7:0]  in_a, in_b;
    logic [3:0]  in_tag, out_tag;
    logic [15:0] out_product;

    wallace_mult_pipe #(.WIDTH(8), .TAG_W(4)) dut (
        .clk        (clk),
        .rst_n      (drst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_signed  (in_signed),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_product(out_product),
        .out_tag    (out_tag)
    );

    // random sweeps: one compare process per width against a plain-arithmetic model
    for (genvar k = 0; k < 3; k++) begin : g_rand
        localparam int W = (k == 0) ? 4 : (k == 1) ? 8 : 16;
        logic             iv, ir, is, ov, orr;
        logic [W-1:0]     ia, ib;
        logic [3:0]       it, ot;
        logic [2*W-1:0]   op;
        logic [2*W+3:0]   q [$];
        logic [2*W+3:0]   e;
        logic             st;
        logic [2*W-1:0]   pp;
        logic [3:0]       pt;

        wallace_mult_pipe #(.WIDTH(W), .TAG_W(4)) u_dut (
            .clk        (clk),
            .rst_n      (rrst_n),
            .in_valid   (iv),
            .in_ready   (ir),
            .in_a       (ia),
            .in_b       (ib),
            .in_signed  (is),
            .in_tag     (it),
            .out_valid  (ov),
            .out_ready  (orr),
            .out_product(op),
            .out_tag    (ot)
        );

        function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
            longint ea, eb;
            ea = longint'(a);
            eb = longint'(b);
            if (s && a[W-1]) ea -= longint'(1) << W;
            if (s && b[W-1]) eb -= longint'(1) << W;
            return (2*W)'(ea * eb);
        endfunction

        initial begin
            iv = 1'b0; ia = '0; ib = '0; is = 1'b0; it = '0; orr = 1'b0;
            st = 1'b0; pp = '0; pt = '0;
            wait (rrst_n === 1'b1);
            for (int c = 0; c < 600; c++) begin
                @(negedge clk);
                if (st) begin
                    chk("rand_hold_valid", ov, 1);
                    chk("rand_hold_product", op, pp);
                    chk("rand_hold_tag", ot, pt);
                end
                st = ov && !orr;
                pp = op;
                pt = ot;
                if (ov && orr) begin
                    chk("rand_unexpected_output", q.size() > 0, 1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        chk("rand_product", op, e[2*W+3:4]);
                        chk("rand_tag", ot, e[3:0]);
                    end
                end
                if (iv && ir) q.push_back({ref_mul(ia, ib, SGN & is), it});
                @(posedge clk);
                #1;
                iv  = (c < 560) && ($urandom_range(0, 3) != 0);
                ia  = ($urandom_range(0, 7) == 0) ? {W{1'b1}} : W'($urandom);
                ib  = ($urandom_range(0, 7) == 0) ? {1'b1, {(W-1){1'b0}}} : W'($urandom);
                is  = 1'($urandom);
                it  = 4'($urandom);
                orr = (c >= 560) || ($urandom_range(0, 3) != 0);
            end
            chk("rand_drained", q.size(), 0);
            done++;
        end
    end

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [3:0] t);
        in_valid = 1'b1; in_a = a; in_b = b; in_signed = s; in_tag = t;
    endtask

    task automatic send_lat(input logic [7:0] a, input logic [7:0] b, input logic s,
                            input logic [3:0] t, input logic [15:0] ex);
        int lat;
        lat = 0;
        @(posedge clk); #1;
        drive(a, b, s, t);
        out_ready = 1'b1;
        @(negedge clk);
        chk("lat_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(negedge clk);
            if (out_valid) lat = i;
        end
        chk("latency", lat, 3);
        chk("lat_product", out_product, ex);
        chk("lat_tag", out_tag, t);
    endtask

    task automatic pair2(input logic [7:0] a1, input logic [7:0] b1, input logic s1, input logic [3:0] t1,
                         input logic [15:0] e1,
                         input logic [7:0] a2, input logic [7:0] b2, input logic s2, input logic [3:0] t2,
                         input logic [15:0] e2);
        logic found;
        found = 1'b0;
        @(posedge clk); #1;
        drive(a1, b1, s1, t1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        drive(a2, b2, s2, t2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (out_valid) found = 1'b1;
        end
        chk("pair_first_valid", found, 1);
        chk("pair_first_product", out_product, e1);
        chk("pair_first_tag", out_tag, t1);
        @(negedge clk);
        chk("pair_second_valid", out_valid, 1);
        chk("pair_second_product", out_product, e2);
        chk("pair_second_tag", out_tag, t2);
    endtask

    int          n_got;
    logic [3:0]  gt [0:7];
    logic [15:0] gp [0:7];

    initial begin
        drst_n = 1'b0; rrst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0; out_ready = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_product", out_product, 0);
        chk("reset_out_tag", out_tag, 0);
        @(negedge clk);
        drst_n = 1'b1;
        rrst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", in_ready, 1);
        chk("post_reset_out_valid", out_valid, 0);

        send_lat(8'hFF, 8'hFF, 1'b0, 4'h5, 16'hFE01);

        pair2(8'h80, 8'h80, 1'b1, 4'h1, 16'h4000,
              8'hFF, 8'h7F, 1'b1, 4'h2, SGN ? 16'hFF81 : 16'h7E81);

        pair2(8'hFF, 8'h7F, 1'b0, 4'h3, 16'h7E81,
              8'hFF, 8'h7F, 1'b1, 4'h4, SGN ? 16'hFF81 : 16'h7E81);

        // backpressure: three pairs fill the pipe, the fourth waits
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            drive(8'(8'h10 + k), 8'h03, 1'b0, 4'(k));
            @(negedge clk);
            chk("bp_in_ready", in_ready, k < 4);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_stall_valid", out_valid, 1);
            chk("bp_stall_tag", out_tag, 1);
            chk("bp_stall_product", out_product, 16'h0033);
            chk("bp_stall_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        n_got = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (j == 0) chk("bp_full_in_ready", in_ready, 1);
            if (out_valid && n_got < 8) begin
                gt[n_got] = out_tag;
                gp[n_got] = out_product;
                n_got++;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        chk("bp_count", n_got, 4);
        for (int k = 0; k < 4 && k < n_got; k++) begin
            chk("bp_order_tag", gt[k], k + 1);
            chk("bp_order_product", gp[k], (16'h11 + k) * 3);
        end

        // reset with two pairs in flight, the first already presented
        out_ready = 1'b0;
        drive(8'h05, 8'h07, 1'b0, 4'h9);
        @(posedge clk); #1;
        drive(8'h06, 8'h07, 1'b0, 4'hA);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_pre_valid", out_valid, 1);
        chk("rst_pre_product", out_product, 16'h0023);
        #2;
        drst_n = 1'b0;
        #1;
        chk("rst_async_valid", out_valid, 0);
        chk("rst_async_product", out_product, 0);
        chk("rst_async_tag", out_tag, 0);
        chk("rst_async_in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        drst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_no_stale", out_valid, 0);
        end
        send_lat(8'h0C, 8'h0D, 1'b0, 4'hE, 16'h009C);

        for (int i = 0; i < 5000 && done < 3; i++) @(posedge clk);
        chk("rand_sweeps_done", done, 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
